// File: rtl/uart_tx_dev_pkg.sv
// uart_tx_dev_pkg: register offsets, bridge window bounds and serialiser states for the UART transmitter
package uart_tx_dev_pkg;
  localparam logic [1:0] UART_DATA = 2'd0;
  localparam logic [1:0] UART_STAT = 2'd1;
  localparam logic [1:0] UART_CTRL = 2'd2;
  localparam logic [1:0] UART_DIV  = 2'd3;
  localparam logic [31:0] StartAddrUART = 32'h0000_7f20;
  localparam logic [31:0] EndAddrUART   = 32'h0000_7f2f;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO that drops pushes when full and ignores pops when empty
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with byte FIFO and drain interrupt
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [15:0] DIV_RESET = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);
  localparam int CW = $clog2(DEPTH + 1);
  uart_state_e state, state_n;
  logic [7:0] shreg, fdout;
  logic [2:0] idx, idx_n;
  logic [15:0] div, divm, bcnt;
  logic [CW-1:0] count;
  logic [1:0] a;
  logic ovr, ien, pop, full, empty, busy, last, push;
  logic unused_bits;
  assign a = Addr[3:2];
  assign unused_bits = ^{Addr[31:4], Din[31:16]};
  assign push = WE && a == UART_DATA;
  assign busy = state != IDLE;
  assign divm = div == '0 ? 16'd1 : div;
  // >= keeps a live DIV shrink from stranding the counter above the new limit
  assign last = bcnt >= divm - 16'd1;
  assign Dout = a == UART_STAT ? {23'b0, ovr, ien, busy, full, empty, 4'(count)} :
                a == UART_CTRL ? {31'b0, ien} :
                a == UART_DIV  ? {16'b0, div} : 32'b0;
  uart_tx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(Din[7:0]),
    .dout(fdout),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    pop = 1'b0;
    tx = 1'b1;
    case (state)
      IDLE: begin
        pop = !empty;
        state_n = empty ? IDLE : START;
      end
      START: begin
        tx = 1'b0;
        state_n = last ? DATA : START;
        idx_n = last ? 3'd0 : idx;
      end
      DATA: begin
        tx = shreg[idx];
        idx_n = last ? idx + 3'd1 : idx;
        state_n = last && idx == 3'd7 ? STOP : DATA;
      end
      STOP: begin
        pop = last && !empty;
        state_n = !last ? STOP : empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      bcnt <= '0;
      ovr <= 1'b0;
      ien <= 1'b0;
      div <= DIV_RESET;
      IRQ <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      bcnt <= (state == IDLE || last) ? 16'd0 : bcnt + 16'd1;
      if (pop) shreg <= fdout;
      ovr <= (push && full) ? 1'b1 : (WE && a == UART_STAT) ? 1'b0 : ovr;
      if (WE && a == UART_CTRL) ien <= Din[0];
      if (WE && a == UART_DIV) div <= Din[15:0];
      IRQ <= ien & empty & ~busy;
    end
  end
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: randomized self-checking bench comparing the serial line and registers to an 8N1 frame model
module tb_uart_tx_dev;
  import uart_tx_dev_pkg::*;
  logic clk = 1'b0, reset = 1'b1, WE = 1'b0, IRQ, tx;
  logic [31:2] Addr = '0;
  logic [31:0] Din = '0, Dout;
  int checks = 0, failures = 0;
  logic [7:0] pb [10];
  bit log_en = 1'b0;
  bit logq [$];

  uart_tx_dev #(.DEPTH(4), .DIV_RESET(16'd16)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .IRQ(IRQ), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (log_en) logq.push_back(tx);

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = {28'h00007f2, a};
    Din = d;
    WE = 1'b1;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = {28'h00007f2, a};
    #1 v = Dout;
  endtask

  task automatic burst(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      Addr = {28'h00007f2, UART_DATA};
      Din = {24'h0, pb[base + i]};
      WE = 1'b1;
    end
    @(negedge clk);
    WE = 1'b0;
  endtask

  function automatic logic expbit(input logic [7:0] b, input int i);
    return i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i - 1];
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
    rd(UART_STAT, v);
    checks++; if (v !== 32'h10) begin failures++; $display("FAIL reset_status got=%h exp=%h", v, 32'h10); end
    rd(UART_DIV, v);
    checks++; if (v !== 32'd16) begin failures++; $display("FAIL reset_div got=%h exp=%h", v, 32'd16); end
    rd(UART_CTRL, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", v); end
    rd(UART_DATA, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_data_read got=%h exp=0", v); end
  endtask

  task automatic test_frame(input logic [7:0] b, input int d);
    logic [31:0] v;
    int dm;
    dm = d == 0 ? 1 : d;
    wr(UART_DIV, d);
    rd(UART_DIV, v);
    checks++; if (v !== 32'(d)) begin failures++; $display("FAIL frame_div_read got=%h exp=%h", v, d); end
    wr(UART_DATA, {24'h0, b});
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL frame_idle_cycle byte=%h got=%b exp=1", b, tx); end
    for (int j = 0; j < 10 * dm; j++) begin
      @(negedge clk);
      checks++;
      if (tx !== expbit(b, j / dm)) begin
        failures++;
        $display("FAIL frame_bit byte=%h div=%0d cycle=%0d got=%b exp=%b", b, d, j, tx, expbit(b, j / dm));
      end
    end
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL frame_end_tx byte=%h got=%b exp=1", b, tx); end
    rd(UART_STAT, v);
    checks++; if (v !== 32'h10) begin failures++; $display("FAIL frame_end_status got=%h exp=%h", v, 32'h10); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic e;
    wr(UART_CTRL, 32'd1);
    wr(UART_DIV, 32'd2);
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL b2b_irq_idle got=%b exp=1", IRQ); end
    pb[0] = 8'h55;
    pb[1] = 8'h0F;
    burst(0, 2);
    for (int i = 0; i < 40; i++) begin
      b = i < 20 ? pb[0] : pb[1];
      e = expbit(b, (i % 20) / 2);
      checks++;
      if (tx !== e || IRQ !== 1'b0) begin
        failures++;
        $display("FAIL b2b_cycle cycle=%0d got tx=%b irq=%b exp tx=%b irq=0", i, tx, IRQ, e);
      end
      @(negedge clk);
    end
    checks++; if (tx !== 1'b1 || IRQ !== 1'b0) begin failures++; $display("FAIL b2b_after_stop got tx=%b irq=%b exp tx=1 irq=0", tx, IRQ); end
    @(negedge clk);
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL b2b_irq_rise got=%b exp=1", IRQ); end
    wr(UART_CTRL, 32'd0);
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL irq_lag_on_clear got=%b exp=1", IRQ); end
    @(negedge clk);
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", IRQ); end
  endtask

  task automatic test_fill_ovr();
    logic [31:0] v;
    logic [7:0] got;
    int p, dm, zeros;
    dm = 4;
    for (int i = 0; i < 10; i++) pb[i] = 8'($urandom);
    wr(UART_DIV, dm);
    logq.delete();
    log_en = 1'b1;
    burst(0, 5);
    rd(UART_STAT, v);
    checks++; if (v !== 32'h64) begin failures++; $display("FAIL fill_status got=%h exp=%h", v, 32'h64); end
    burst(5, 5);
    rd(UART_STAT, v);
    checks++; if (v !== 32'h164) begin failures++; $display("FAIL ovr_set_status got=%h exp=%h", v, 32'h164); end
    wr(UART_STAT, 32'h0);
    rd(UART_STAT, v);
    checks++; if (v !== 32'h64) begin failures++; $display("FAIL ovr_clear_status got=%h exp=%h", v, 32'h64); end
    repeat (240) @(negedge clk);
    log_en = 1'b0;
    p = 0;
    for (int f = 0; f < 5; f++) begin
      while (p < logq.size() && logq[p] == 1'b1) p++;
      checks++;
      if (p + 10 * dm > logq.size()) begin
        failures++;
        $display("FAIL fifo_frame_missing frame=%0d got=none exp=%h", f, pb[f]);
        break;
      end
      for (int i = 0; i < 8; i++) got[i] = logq[p + (i + 1) * dm + dm / 2];
      if (got !== pb[f] || logq[p + 9 * dm + dm / 2] !== 1'b1) begin
        failures++;
        $display("FAIL fifo_frame_data frame=%0d got=%h exp=%h", f, got, pb[f]);
      end
      p += 10 * dm;
    end
    zeros = 0;
    for (int i = p; i < logq.size(); i++) zeros += logq[i] == 1'b0 ? 1 : 0;
    checks++; if (zeros != 0) begin failures++; $display("FAIL dropped_bytes_sent got=%0d low cycles exp=0", zeros); end
    rd(UART_STAT, v);
    checks++; if (v !== 32'h10) begin failures++; $display("FAIL drain_status got=%h exp=%h", v, 32'h10); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    logic [7:0] b;
    int highs;
    b = 8'($urandom);
    wr(UART_DIV, 32'd4);
    wr(UART_CTRL, 32'd1);
    wr(UART_DATA, {24'h0, b});
    repeat (18) @(negedge clk);
    checks++; if (tx !== b[3]) begin failures++; $display("FAIL midframe_bit3 got=%b exp=%b", tx, b[3]); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (tx !== 1'b1 || IRQ !== 1'b0) begin failures++; $display("FAIL midreset_lines got tx=%b irq=%b exp tx=1 irq=0", tx, IRQ); end
    rd(UART_STAT, v);
    checks++; if (v !== 32'h10) begin failures++; $display("FAIL midreset_status got=%h exp=%h", v, 32'h10); end
    rd(UART_DIV, v);
    checks++; if (v !== 32'd16) begin failures++; $display("FAIL midreset_div got=%h exp=%h", v, 32'd16); end
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      highs += (tx === 1'b1 && IRQ === 1'b0) ? 1 : 0;
    end
    checks++; if (highs != 60) begin failures++; $display("FAIL midreset_quiet got=%0d quiet cycles exp=60", highs); end
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, 4);
    test_frame(8'hFF, 0);
    for (int i = 0; i < 3; i++) test_frame(8'($urandom), int'($urandom_range(0, 5)));
    test_back_to_back();
    test_fill_ovr();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
